uart_cmd_parser: RTL and testbench

- Consumes received bytes from the uart_rx FIFO and parses ASCII configuration commands.
- Commits parsed values to the PWM generator configuration registers: frequency in Hz and duty in percent.
- Sits between uart_rx (show-ahead FIFO interface: fifo_data, fifo_empty, fifo_read) and the PWM core.
- Reports malformed or out-of-range commands with an error pulse and leaves the configuration unchanged.

---
 rtl/uart_cmd_parser.sv | 139 +++++++++++++
 tb/tb_uart_cmd_parser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: turns "F<hz>" / "D<pct>" lines from the rx FIFO into
// committed PWM configuration, flagging malformed or out-of-range commands.
module uart_cmd_parser #(
   parameter int FREQ_W     = 32,
   parameter int FREQ_MIN   = 1,
   parameter int FREQ_MAX   = 1_000_000,
   parameter int DUTY_MAX   = 100,
   parameter int FREQ_RESET = 1000,
   parameter int DUTY_RESET = 50,
   parameter int MAX_DIGITS = 10
) (
   input  logic              clk_50mhz,
   input  logic              rst_n,
   input  logic [7:0]        fifo_data,
   input  logic              fifo_empty,
   output logic              fifo_read,
   output logic [FREQ_W-1:0] freq_hz,
   output logic [6:0]        duty_pct,
   output logic              cfg_update,
   output logic              cmd_error,
   output logic              busy
);

   localparam int CNT_W = $clog2(MAX_DIGITS + 1);
   localparam logic [FREQ_W-1:0] F_MIN   = FREQ_W'(FREQ_MIN);
   localparam logic [FREQ_W-1:0] F_MAX   = FREQ_W'(FREQ_MAX);
   localparam logic [FREQ_W-1:0] D_MAX   = FREQ_W'(DUTY_MAX);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);

   typedef enum logic [2:0] {IDLE, CMD, DIGITS, COMMIT, DISCARD} state_t;

   state_t              state;
   logic                tgt_freq;
   logic                seen_space;
   logic [FREQ_W-1:0]   acc;
   logic [CNT_W-1:0]    cnt;

   // acc*10 + d, kept 4 bits wider so overflow past FREQ_W bits is visible
   function automatic logic [FREQ_W+3:0] acc_step(input logic [FREQ_W-1:0] a,
                                                  input logic [3:0] d);
      logic [FREQ_W+3:0] a_ext;
      a_ext = {4'd0, a};
      return (a_ext << 3) + (a_ext << 1) + {{FREQ_W{1'b0}}, d};
   endfunction

   logic              is_digit, is_term, is_f, is_d, is_space, take, acc_ovf;
   logic [FREQ_W+3:0] acc_nxt;

   assign is_digit = (fifo_data >= 8'h30) && (fifo_data <= 8'h39);
   assign is_term  = (fifo_data == 8'h0D) || (fifo_data == 8'h0A);
   assign is_f     = (fifo_data == 8'h46) || (fifo_data == 8'h66);
   assign is_d     = (fifo_data == 8'h44) || (fifo_data == 8'h64);
   assign is_space = (fifo_data == 8'h20);
   assign acc_nxt  = acc_step(acc, fifo_data[3:0]);
   assign acc_ovf  = (acc_nxt[FREQ_W+3:FREQ_W] != 4'd0);
   // The pop strobe of the previous byte blocks a second read of the same head
   assign take     = !fifo_empty && !fifo_read;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         tgt_freq   <= 1'b0;
         seen_space <= 1'b0;
         acc        <= '0;
         cnt        <= '0;
         fifo_read  <= 1'b0;
         cfg_update <= 1'b0;
         cmd_error  <= 1'b0;
         freq_hz    <= FREQ_W'(FREQ_RESET);
         duty_pct   <= 7'(DUTY_RESET);
      end else begin
         fifo_read  <= 1'b0;
         cfg_update <= 1'b0;
         cmd_error  <= 1'b0;
         if (state == COMMIT) begin
            if (tgt_freq && (acc >= F_MIN) && (acc <= F_MAX)) begin
               freq_hz    <= acc;
               cfg_update <= 1'b1;
            end else if (!tgt_freq && (acc <= D_MAX)) begin
               duty_pct   <= acc[6:0];
               cfg_update <= 1'b1;
            end else begin
               cmd_error  <= 1'b1;
            end
            state <= IDLE;
         end else if (take) begin
            fifo_read <= 1'b1;
            case (state)
               IDLE: begin
                  if (is_f || is_d) begin
                     tgt_freq   <= is_f;
                     seen_space <= 1'b0;
                     acc        <= '0;
                     cnt        <= '0;
                     state      <= CMD;
                  end else if (!is_term) begin
                     cmd_error <= 1'b1;
                     state     <= DISCARD;
                  end
               end
               CMD: begin
                  if (is_space && !seen_space) begin
                     seen_space <= 1'b1;
                  end else if (is_digit) begin
                     acc   <= FREQ_W'(fifo_data[3:0]);
                     cnt   <= CNT_W'(1);
                     state <= DIGITS;
                  end else begin
                     cmd_error <= 1'b1;
                     state     <= is_term ? IDLE : DISCARD;
                  end
               end
               DIGITS: begin
                  if (is_digit) begin
                     if (acc_ovf || (cnt == CNT_MAX)) begin
                        cmd_error <= 1'b1;
                        state     <= DISCARD;
                     end else begin
                        acc <= acc_nxt[FREQ_W-1:0];
                        cnt <= cnt + CNT_W'(1);
                     end
                  end else if (is_term) begin
                     state <= COMMIT;
                  end else begin
                     cmd_error <= 1'b1;
                     state     <= DISCARD;
                  end
               end
               DISCARD: begin
                  if (is_term) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a line-level reference model predicts
// each cfg_update/cmd_error event; a monitor pops and compares them.
module tb_uart_cmd_parser;

   localparam int MAX_DIGITS = 10;

   logic        clk_50mhz;
   logic        rst_n;
   logic [7:0]  fifo_data;
   logic        fifo_empty;
   logic        fifo_read;
   logic [31:0] freq_hz;
   logic [6:0]  duty_pct;
   logic        cfg_update;
   logic        cmd_error;
   logic        busy;

   uart_cmd_parser dut (
      .clk_50mhz (clk_50mhz),
      .rst_n     (rst_n),
      .fifo_data (fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_read (fifo_read),
      .freq_hz   (freq_hz),
      .duty_pct  (duty_pct),
      .cfg_update(cfg_update),
      .cmd_error (cmd_error),
      .busy      (busy)
   );

   initial begin
      clk_50mhz = 1'b0;
      forever #5 clk_50mhz = ~clk_50mhz;
   end

   typedef struct {
      bit          is_err;
      logic [31:0] f;
      logic [6:0]  d;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  fifo_q[$];
   int          checks = 0;
   int          errors = 0;
   longint      m_freq = 1000;
   longint      m_duty = 50;

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Grammar as a whole-line check: letter, optional space, 1..MAX_DIGITS digits
   function automatic bit parse_ok(input string s, output bit is_f, output longint v);
      int i;
      v = 0;
      is_f = 0;
      if (s.len() == 0) return 0;
      if (s[0] == 8'h46 || s[0] == 8'h66) is_f = 1;
      else if (s[0] == 8'h44 || s[0] == 8'h64) is_f = 0;
      else return 0;
      i = 1;
      if (i < s.len() && s[i] == 8'h20) i++;
      if ((s.len() - i) < 1 || (s.len() - i) > MAX_DIGITS) return 0;
      for (int k = i; k < s.len(); k++) begin
         if (s[k] < 8'h30 || s[k] > 8'h39) return 0;
         v = v * 10 + longint'(s[k] - 8'h30);
      end
      if (v > 64'hFFFF_FFFF) return 0;
      return 1;
   endfunction

   function automatic void model_line(input string body);
      bit     is_f;
      longint v;
      exp_t   e;
      if (body.len() == 0) return;
      e.is_err = 1;
      if (parse_ok(body, is_f, v)) begin
         if (is_f && v >= 1 && v <= 1_000_000) begin
            m_freq = v;
            e.is_err = 0;
         end else if (!is_f && v <= 100) begin
            m_duty = v;
            e.is_err = 0;
         end
      end
      e.f = m_freq[31:0];
      e.d = m_duty[6:0];
      exp_q.push_back(e);
   endfunction

   task automatic drive();
      fifo_empty = (fifo_q.size() == 0);
      fifo_data  = fifo_empty ? 8'h00 : fifo_q[0];
   endtask

   task automatic tick();
      bit rd;
      @(negedge clk_50mhz);
      rd = fifo_read;
      @(posedge clk_50mhz);
      #1;
      if (rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
      drive();
   endtask

   task automatic feed_line(input string body, input bit lf);
      model_line(body);
      for (int i = 0; i < body.len(); i++) fifo_q.push_back(body[i]);
      fifo_q.push_back(lf ? 8'h0A : 8'h0D);
      drive();
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((fifo_q.size() != 0 || busy || exp_q.size() != 0) && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout fifo_left=%0d exp_left=%0d required=0", fifo_q.size(), exp_q.size());
      end
      repeat (4) tick();
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_freq"}, freq_hz, 1000);
      chk({tag, "_duty"}, duty_pct, 50);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_strobes"}, {fifo_read, cfg_update, cmd_error}, 0);
   endtask

   function automatic byte rand_junk();
      return byte'($urandom_range(33, 126));
   endfunction

   function automatic string rand_line();
      byte   letters[4];
      byte   ch;
      string s;
      int    k, m, n;
      letters = '{8'h46, 8'h66, 8'h44, 8'h64};
      s = "";
      k = $urandom_range(0, 99);
      ch = (k < 88) ? letters[$urandom_range(0, 3)] : rand_junk();
      s = {s, $sformatf("%c", ch)};
      k = $urandom_range(0, 9);
      if (k >= 6) s = {s, " "};
      if (k == 9) s = {s, " "};
      if ($urandom_range(0, 5) == 0) s = {s, "00"};
      m = $urandom_range(0, 9);
      if (m == 0) begin
         s = s;
      end else if (m <= 3) begin
         s = {s, $sformatf("%0d", $urandom_range(0, 130))};
      end else if (m <= 6) begin
         s = {s, $sformatf("%0d", $urandom_range(0, 1_100_000))};
      end else if (m == 7) begin
         n = $urandom_range(9, 12);
         for (int i = 0; i < n; i++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
      end else if (m == 8) begin
         s = {s, $sformatf("%0d%c%0d", $urandom_range(0, 99), rand_junk(), $urandom_range(0, 99))};
      end else begin
         s = {s, $sformatf("%0d", $urandom())};
      end
      return s;
   endfunction

   // Monitor: every strobe must match the next predicted event
   initial begin
      exp_t e;
      bit   prev_rd;
      prev_rd = 0;
      forever begin
         @(negedge clk_50mhz);
         if (cfg_update && cmd_error) begin
            checks++;
            errors++;
            $display("FAIL both_strobes cfg_update=1 cmd_error=1 required=exclusive");
         end
         if (cfg_update || cmd_error) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_strobe cfg_update=%0b cmd_error=%0b required=none", cfg_update, cmd_error);
            end else begin
               e = exp_q.pop_front();
               chk("event_is_error", cmd_error, e.is_err);
               chk("event_freq", freq_hz, e.f);
               chk("event_duty", duty_pct, e.d);
            end
         end
         if (fifo_read) begin
            chk("read_while_empty", fifo_empty, 0);
            chk("read_back_to_back", prev_rd, 0);
         end
         prev_rd = fifo_read;
      end
   end

   initial begin
      rst_n = 1'b0;
      drive();
      repeat (3) tick();
      chk_reset_state("rst");
      rst_n = 1'b1;
      repeat (4) tick();
      chk("idle_no_read", fifo_read, 0);

      feed_line("F2500", 0);
      drain();
      chk("f2500_freq", freq_hz, 2500);
      chk("f2500_duty", duty_pct, 50);
      feed_line("d 75", 1);
      feed_line("D101", 0);
      feed_line("X12", 0);
      feed_line("F0", 0);
      feed_line("F1000001", 0);
      feed_line("F9", 0);
      feed_line("F99999999999", 0);
      feed_line("D10", 0);
      feed_line("", 0);
      feed_line("", 1);
      feed_line("", 0);
      drain();
      chk("directed_freq", freq_hz, 9);
      chk("directed_duty", duty_pct, 10);

      // Partial command killed by reset
      fifo_q.push_back(8'h46);
      fifo_q.push_back(8'h31);
      fifo_q.push_back(8'h32);
      drive();
      repeat (12) tick();
      chk("partial_busy", busy, 1);
      rst_n = 1'b0;
      m_freq = 1000;
      m_duty = 50;
      repeat (2) tick();
      chk_reset_state("midrst");
      rst_n = 1'b1;
      feed_line("34", 0);
      drain();

      for (int n = 0; n < 150; n++) begin
         feed_line(rand_line(), $urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) feed_line("", 1);
         repeat ($urandom_range(0, 20)) tick();
      end
      drain();
      chk("final_freq", freq_hz, m_freq);
      chk("final_duty", duty_pct, m_duty);
      chk("final_pending", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
